mips_multicycle_control: RTL and testbench
==========================================

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
Parameters:
REQ-001 The block SHALL have parameter ALU_SEL_W, default 3, the width of select_bits_ALU (values above 3 zero-extend the codes in REQ-011).
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 15, the maximum number of cycles to wait for mem_ready before entering ERROR.
REQ-003 The block SHALL have parameter CNT_W, default 16, the width of instr_count.
Ports:
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 opcode  in  6  IR[31:26].
REQ-007 function_code  in  6  IR[5:0].
REQ-008 Handshake inputs:
- mem_ready  in  1  memory completes the current access.
- zero  in  1  ALU zero flag.
REQ-009 ALU control outputs:
- select_bits_ALU  out  ALU_SEL_W
- shift  out  1
- sltu  out  1
REQ-010 Datapath strobes and status outputs:
- pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_imm  out  1 each
- instr_done  out  1
- illegal  out  1
- state  out  3
- instr_count  out  CNT_W

Function
REQ-011 The R-type decode (opcode 000000) SHALL map function_code as follows:
- add/addu 100000/100001 -> ALU 010.
- sub/subu 100010/100011 -> 110.
- and 100100 -> 000.
- or 100101 -> 001.
- nor 100111 -> 100.
- sltu 101011 -> 111, sltu=1.
- sll 000000 -> 011, shift=1.
- srl 000010 -> 101, shift=1.
REQ-012 The I-type decode SHALL map:
- lw 100011 and sw 101011 -> ALU 010, alu_src_imm=1.
- addi 001000 -> ALU 010, alu_src_imm=1.
- beq 000100 -> ALU 110.
REQ-013 Any other opcode or function_code SHALL be illegal.
REQ-014 States SHALL be encoded as FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=5, and state SHALL output the current encoding.
REQ-015 FETCH:
- mem_read=1.
- On mem_ready=1: ir_write=1 and pc_write=1 for that cycle, then -> DECODE.
REQ-016 DECODE:
- opcode and function_code are latched into internal registers.
- illegal -> ERROR; otherwise -> EXEC.
REQ-017 EXEC:
- select_bits_ALU, shift and sltu are driven from the latched decode.
- R-type/addi -> WB; lw/sw -> MEM.
- beq: pc_write=zero, instr_done=1, -> FETCH.
REQ-018 MEM:
- lw: mem_read=1 until mem_ready, then -> WB.
- sw: mem_write=1 until mem_ready, then instr_done=1 and -> FETCH.
REQ-019 WB:
- reg_write=1 and instr_done=1 for one cycle, then -> FETCH.
- reg_dst=1 for R-type; mem_to_reg=1 for lw.
REQ-020 Memory timeout:
- A wait counter SHALL clear on entry to FETCH or MEM.
- It SHALL count each cycle mem_ready=0 in those states.
- Reaching MEM_TIMEOUT SHALL force -> ERROR.
- mem_ready arriving on the same cycle as the limit SHALL win.
REQ-021 ERROR SHALL hold illegal=1, keep all strobes at 0, and be left only by reset.
REQ-022 instr_count SHALL increment on each instr_done and wrap from all-ones to 0.
REQ-023 All strobes SHALL be 0 in any state or condition not listed above.

Reset
REQ-024 reset=1 SHALL immediately force:
- state=FETCH, all strobes 0, illegal=0.
- select_bits_ALU=0, shift=0, sltu=0.
- instr_count=0, wait counter=0.
REQ-025 Reset asserted mid-instruction SHALL abandon that instruction with no instr_done.
REQ-026 After reset deasserts, the first cycle SHALL be FETCH with mem_read=1.

Structure
REQ-027 The state encodings, opcode/funct constants and ALU select codes SHALL reside in shared package mips_ctrl_pkg.
REQ-028 Decode SHALL be a combinational sub-module alu_decoder (opcode, function_code -> select_bits_ALU, shift, sltu, illegal).
REQ-029 The FSM, wait counter and instr_count SHALL reside in the top module.

Verification
REQ-030 R-type add, mem_ready=1 every cycle -> FETCH, DECODE, EXEC (ALU 010), WB with reg_write=1 and reg_dst=1, instr_done; instr_count=1.
REQ-031 lw with mem_ready delayed 3 cycles in MEM -> mem_read held 4 cycles, WB mem_to_reg=1, total 8 cycles.
REQ-032 beq with zero=1 -> pc_write=1 in EXEC; with zero=0 -> pc_write=0; instr_done in EXEC both times.
REQ-033 Cases that enter ERROR:
- function_code 111111 with opcode 0 -> ERROR after DECODE, illegal=1 until reset.
- mem_ready=0 for 15 cycles in FETCH -> ERROR.
REQ-034 Asynchronous reset mid-MEM of an sw -> state=0, mem_write=0 before the next clock edge, and instr_count unchanged.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: FSM states, opcodes, funct codes, ALU selects.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    // Primary opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // R-type function codes, IR[5:0]
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;

    // ALU select codes (3-bit native width)
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SLL  = 3'b011;
    localparam logic [2:0] ALU_NOR  = 3'b100;
    localparam logic [2:0] ALU_SRL  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational instruction decode: opcode/funct -> ALU select, shift, sltu, illegal flag.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input every cycle.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_function_code,
    output logic [2:0] o_alu_sel,
    output logic       o_shift,
    output logic       o_sltu,
    output logic       o_illegal
);

    // Decode table; anything not recognised is flagged illegal with a zero select.
    always_comb begin
        o_alu_sel = ALU_AND;
        o_shift   = 1'b0;
        o_sltu    = 1'b0;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_function_code)
                    FN_ADD, FN_ADDU: o_alu_sel = ALU_ADD;
                    FN_SUB, FN_SUBU: o_alu_sel = ALU_SUB;
                    FN_AND:          o_alu_sel = ALU_AND;
                    FN_OR:           o_alu_sel = ALU_OR;
                    FN_NOR:          o_alu_sel = ALU_NOR;
                    FN_SLTU: begin
                        o_alu_sel = ALU_SLTU;
                        o_sltu    = 1'b1;
                    end
                    FN_SLL: begin
                        o_alu_sel = ALU_SLL;
                        o_shift   = 1'b1;
                    end
                    FN_SRL: begin
                        o_alu_sel = ALU_SRL;
                        o_shift   = 1'b1;
                    end
                    default:         o_illegal = 1'b1;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI: o_alu_sel = ALU_ADD;
            OP_BEQ:                o_alu_sel = ALU_SUB;
            default:               o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/ERROR) with memory-wait timeout and retired-instruction counter.
// Latency: 4 cycles for R-type/addi, 3 for beq, 4 for sw, 5 for lw, plus memory wait cycles in FETCH/MEM.
// Backpressure: FETCH and MEM stall on mem_ready=0; MEM_TIMEOUT consecutive stall cycles force the sticky ERROR state.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_SEL_W   = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic [5:0]           function_code,
    input  logic                 mem_ready,
    input  logic                 zero,
    output logic [ALU_SEL_W-1:0] select_bits_ALU,
    output logic                 shift,
    output logic                 sltu,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 alu_src_imm,
    output logic                 instr_done,
    output logic                 illegal,
    output logic [2:0]           state,
    output logic [CNT_W-1:0]     instr_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            r_state;
    state_t            w_next;
    logic [5:0]        r_opcode;
    logic [5:0]        r_funct;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_count;

    logic [5:0] w_dec_op;
    logic [5:0] w_dec_fn;
    logic [2:0] w_dec_sel;
    logic       w_dec_shift;
    logic       w_dec_sltu;
    logic       w_dec_illegal;

    logic w_is_rtype, w_is_lw, w_is_sw, w_is_beq, w_is_addi;
    logic w_timeout;

    logic [2:0] w_sel;
    logic w_shift, w_sltu, w_pc_write, w_ir_write, w_mem_read, w_mem_write;
    logic w_reg_write, w_reg_dst, w_mem_to_reg, w_alu_src_imm, w_done;

    // In DECODE the live IR fields decide legality; afterwards the latched copy drives the ALU.
    assign w_dec_op = (r_state == ST_DECODE) ? opcode        : r_opcode;
    assign w_dec_fn = (r_state == ST_DECODE) ? function_code : r_funct;

    alu_decoder u_dec (
        .i_opcode        (w_dec_op),
        .i_function_code (w_dec_fn),
        .o_alu_sel       (w_dec_sel),
        .o_shift         (w_dec_shift),
        .o_sltu          (w_dec_sltu),
        .o_illegal       (w_dec_illegal)
    );

    assign w_is_rtype = (r_opcode == OP_RTYPE);
    assign w_is_lw    = (r_opcode == OP_LW);
    assign w_is_sw    = (r_opcode == OP_SW);
    assign w_is_beq   = (r_opcode == OP_BEQ);
    assign w_is_addi  = (r_opcode == OP_ADDI);

    // A late mem_ready on the limit cycle still completes the access.
    assign w_timeout = !mem_ready && (r_wait >= WAIT_W'(MEM_TIMEOUT - 1));

    // Next-state and raw strobe generation.
    always_comb begin
        w_next        = r_state;
        w_sel         = 3'b000;
        w_shift       = 1'b0;
        w_sltu        = 1'b0;
        w_pc_write    = 1'b0;
        w_ir_write    = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_reg_dst     = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_alu_src_imm = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = ST_DECODE;
                end else if (w_timeout) begin
                    w_next = ST_ERROR;
                end
            end
            ST_DECODE: begin
                w_next = w_dec_illegal ? ST_ERROR : ST_EXEC;
            end
            ST_EXEC: begin
                w_sel   = w_dec_sel;
                w_shift = w_dec_shift;
                w_sltu  = w_dec_sltu;
                if (w_is_beq) begin
                    w_pc_write = zero;
                    w_done     = 1'b1;
                    w_next     = ST_FETCH;
                end else if (w_is_lw || w_is_sw) begin
                    w_alu_src_imm = 1'b1;
                    w_next        = ST_MEM;
                end else begin
                    w_alu_src_imm = w_is_addi;
                    w_next        = ST_WB;
                end
            end
            ST_MEM: begin
                w_mem_read  = w_is_lw;
                w_mem_write = !w_is_lw;
                if (mem_ready) begin
                    if (w_is_lw) begin
                        w_next = ST_WB;
                    end else begin
                        w_done = 1'b1;
                        w_next = ST_FETCH;
                    end
                end else if (w_timeout) begin
                    w_next = ST_ERROR;
                end
            end
            ST_WB: begin
                w_reg_write  = 1'b1;
                w_done       = 1'b1;
                w_reg_dst    = w_is_rtype;
                w_mem_to_reg = w_is_lw;
                w_next       = ST_FETCH;
            end
            ST_ERROR: w_next = ST_ERROR;
            default:  w_next = ST_ERROR;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_FETCH;
        else       r_state <= w_next;
    end

    // Latch the instruction fields while in DECODE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opcode <= 6'd0;
            r_funct  <= 6'd0;
        end else if (r_state == ST_DECODE) begin
            r_opcode <= opcode;
            r_funct  <= function_code;
        end
    end

    // Memory wait counter: cleared on entry to FETCH/MEM, counts stalled cycles there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else if ((w_next != r_state) && (w_next == ST_FETCH || w_next == ST_MEM)) begin
            r_wait <= '0;
        end else if ((r_state == ST_FETCH || r_state == ST_MEM) && !mem_ready) begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_count <= '0;
        else if (w_done) r_count <= r_count + CNT_W'(1);
    end

    // While reset is high every strobe is held low, independent of the clock.
    assign select_bits_ALU = reset ? '0 : ALU_SEL_W'(w_sel);
    assign shift           = w_shift       & ~reset;
    assign sltu            = w_sltu        & ~reset;
    assign pc_write        = w_pc_write    & ~reset;
    assign ir_write        = w_ir_write    & ~reset;
    assign mem_read        = w_mem_read    & ~reset;
    assign mem_write       = w_mem_write   & ~reset;
    assign reg_write       = w_reg_write   & ~reset;
    assign reg_dst         = w_reg_dst     & ~reset;
    assign mem_to_reg      = w_mem_to_reg  & ~reset;
    assign alu_src_imm     = w_alu_src_imm & ~reset;
    assign instr_done      = w_done        & ~reset;
    assign illegal         = (r_state == ST_ERROR) & ~reset;
    assign state           = r_state;
    assign instr_count     = r_count;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle MIPS controller with hand-computed per-cycle expectations.
// Latency: checks each cycle 2 time units after the rising edge.
// Backpressure: mem_ready is driven per step to exercise stalls and timeouts.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] function_code;
    logic       mem_ready;
    logic       zero;
    logic [2:0] select_bits_ALU;
    logic       shift, sltu, pc_write, ir_write, mem_read, mem_write;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_imm, instr_done, illegal;
    logic [2:0] state;
    logic [2:0] instr_count;

    int         n_run  = 0;
    int         n_fail = 0;
    logic [2:0] exp_cnt;
    logic [9:0] strb;

    localparam logic [9:0] PCW  = 10'h200;
    localparam logic [9:0] IRW  = 10'h100;
    localparam logic [9:0] MRD  = 10'h080;
    localparam logic [9:0] MWR  = 10'h040;
    localparam logic [9:0] RGW  = 10'h020;
    localparam logic [9:0] RDST = 10'h010;
    localparam logic [9:0] M2R  = 10'h008;
    localparam logic [9:0] IMM  = 10'h004;
    localparam logic [9:0] DONE = 10'h002;
    localparam logic [9:0] ILL  = 10'h001;

    assign strb = {pc_write, ir_write, mem_read, mem_write, reg_write,
                   reg_dst, mem_to_reg, alu_src_imm, instr_done, illegal};

    mips_multicycle_control #(
        .ALU_SEL_W   (3),
        .MEM_TIMEOUT (15),
        .CNT_W       (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .opcode          (opcode),
        .function_code   (function_code),
        .mem_ready       (mem_ready),
        .zero            (zero),
        .select_bits_ALU (select_bits_ALU),
        .shift           (shift),
        .sltu            (sltu),
        .pc_write        (pc_write),
        .ir_write        (ir_write),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .reg_write       (reg_write),
        .reg_dst         (reg_dst),
        .mem_to_reg      (mem_to_reg),
        .alu_src_imm     (alu_src_imm),
        .instr_done      (instr_done),
        .illegal         (illegal),
        .state           (state),
        .instr_count     (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cyc(input string tag, input logic [2:0] exp_st, input logic [9:0] exp_strb);
        chk({tag, "_state"}, 32'(state), 32'(exp_st));
        chk({tag, "_strb"}, 32'(strb), 32'(exp_strb));
    endtask

    task automatic chk_alu(input string tag, input logic [2:0] sel, input logic sh, input logic sl);
        chk({tag, "_sel"}, 32'(select_bits_ALU), 32'(sel));
        chk({tag, "_shift"}, 32'(shift), 32'(sh));
        chk({tag, "_sltu"}, 32'(sltu), 32'(sl));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full FETCH/DECODE/EXEC/WB pass; entered 1 unit after an edge in FETCH with mem_ready=1.
    task automatic run_alu(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic [2:0] sel, input logic sh, input logic sl,
                           input logic imm, input logic rd);
        opcode = op;
        function_code = fn;
        #1;
        chk_cyc({tag, "_F"}, 3'd0, PCW | IRW | MRD);
        tick(); #1;
        chk_cyc({tag, "_D"}, 3'd1, 10'h000);
        tick(); #1;
        chk_cyc({tag, "_E"}, 3'd2, imm ? IMM : 10'h000);
        chk_alu({tag, "_E"}, sel, sh, sl);
        tick(); #1;
        chk_cyc({tag, "_W"}, 3'd4, RGW | (rd ? RDST : 10'h000) | DONE);
        tick();
        exp_cnt = exp_cnt + 3'd1;
        chk({tag, "_cnt"}, 32'(instr_count), 32'(exp_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0;
        opcode = 6'd0; function_code = 6'd0; exp_cnt = 3'd0;
        #1;
        chk_cyc("rst", 3'd0, 10'h000);
        chk_alu("rst", 3'b000, 1'b0, 1'b0);
        chk("rst_cnt", 32'(instr_count), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0; #1;
        chk_cyc("post_rst", 3'd0, MRD);

        // add, IR fields scrambled after DECODE to prove they were latched
        tick();
        mem_ready = 1'b1; opcode = 6'b000000; function_code = 6'b100000; #1;
        chk_cyc("add_F", 3'd0, PCW | IRW | MRD);
        tick(); #1;
        chk_cyc("add_D", 3'd1, 10'h000);
        tick();
        opcode = 6'b111111; function_code = 6'b111111; #1;
        chk_cyc("add_E", 3'd2, 10'h000);
        chk_alu("add_E", 3'b010, 1'b0, 1'b0);
        tick(); #1;
        chk_cyc("add_W", 3'd4, RGW | RDST | DONE);
        chk("add_W_cnt", 32'(instr_count), 32'd0);
        tick();
        exp_cnt = 3'd1;
        chk("add_cnt", 32'(instr_count), 32'(exp_cnt));

        // lw with 3 stalled MEM cycles: 8 cycles total
        opcode = 6'b100011; function_code = 6'd0; #1;
        chk_cyc("lw_F", 3'd0, PCW | IRW | MRD);
        tick(); #1;
        chk_cyc("lw_D", 3'd1, 10'h000);
        tick(); #1;
        chk_cyc("lw_E", 3'd2, IMM);
        chk_alu("lw_E", 3'b010, 1'b0, 1'b0);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_cyc("lw_Mwait", 3'd3, MRD);
            tick();
        end
        mem_ready = 1'b1; #1;
        chk_cyc("lw_Mrdy", 3'd3, MRD);
        tick(); #1;
        chk_cyc("lw_W", 3'd4, RGW | M2R | DONE);
        tick();
        exp_cnt = 3'd2;
        chk("lw_cnt", 32'(instr_count), 32'(exp_cnt));

        // beq taken and not taken
        for (int z = 1; z >= 0; z--) begin
            opcode = 6'b000100; #1;
            chk_cyc("beq_F", 3'd0, PCW | IRW | MRD);
            tick(); #1;
            chk_cyc("beq_D", 3'd1, 10'h000);
            tick();
            zero = (z == 1); #1;
            chk_cyc("beq_E", 3'd2, ((z == 1) ? PCW : 10'h000) | DONE);
            chk_alu("beq_E", 3'b110, 1'b0, 1'b0);
            tick();
            exp_cnt = exp_cnt + 3'd1;
            chk("beq_cnt", 32'(instr_count), 32'(exp_cnt));
            chk("beq_next", 32'(state), 32'd0);
        end
        zero = 1'b0;

        // remaining decodes; counter wraps 7 -> 0 along the way
        run_alu("sub",  6'b000000, 6'b100010, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1);
        run_alu("and",  6'b000000, 6'b100100, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        run_alu("or",   6'b000000, 6'b100101, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        run_alu("nor",  6'b000000, 6'b100111, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1);
        run_alu("sltu", 6'b000000, 6'b101011, 3'b111, 1'b0, 1'b1, 1'b0, 1'b1);
        run_alu("sll",  6'b000000, 6'b000000, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1);
        run_alu("srl",  6'b000000, 6'b000010, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1);
        run_alu("subu", 6'b000000, 6'b100011, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1);
        run_alu("addu", 6'b000000, 6'b100001, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
        run_alu("addi", 6'b001000, 6'b111111, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("wrap_cnt", 32'(instr_count), 32'd6);

        // illegal funct -> ERROR, sticky
        opcode = 6'b000000; function_code = 6'b111111; #1;
        chk_cyc("ill_F", 3'd0, PCW | IRW | MRD);
        tick(); #1;
        chk_cyc("ill_D", 3'd1, 10'h000);
        tick(); #1;
        chk_cyc("ill_ERR", 3'd5, ILL);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk_cyc("ill_hold", 3'd5, ILL);
        end
        chk("ill_cnt", 32'(instr_count), 32'(exp_cnt));
        reset = 1'b1; #1;
        chk_cyc("rst2", 3'd0, 10'h000);
        chk("rst2_cnt", 32'(instr_count), 32'd0);
        exp_cnt = 3'd0;
        tick();
        reset = 1'b0;

        // illegal opcode -> ERROR
        opcode = 6'b000010; #1;
        chk_cyc("illop_F", 3'd0, PCW | IRW | MRD);
        tick(); #1;
        chk_cyc("illop_D", 3'd1, 10'h000);
        tick(); #1;
        chk_cyc("illop_ERR", 3'd5, ILL);

        // 15 stalled FETCH cycles -> ERROR
        reset = 1'b1; #1; tick();
        reset = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            chk_cyc("to_F", 3'd0, MRD);
            tick();
        end
        #1;
        chk_cyc("to_ERR", 3'd5, ILL);

        // sw: reset asserted mid-MEM drops everything before the next edge
        reset = 1'b1; #1; tick();
        reset = 1'b0; mem_ready = 1'b1; opcode = 6'b101011; #1;
        chk_cyc("sw_F", 3'd0, PCW | IRW | MRD);
        tick(); #1;
        chk_cyc("sw_D", 3'd1, 10'h000);
        tick(); #1;
        chk_cyc("sw_E", 3'd2, IMM);
        chk_alu("sw_E", 3'b010, 1'b0, 1'b0);
        tick();
        mem_ready = 1'b0; #1;
        chk_cyc("sw_M", 3'd3, MWR);
        reset = 1'b1; #1;
        chk_cyc("sw_rst", 3'd0, 10'h000);
        chk("sw_rst_cnt", 32'(instr_count), 32'd0);
        tick();
        reset = 1'b0; #1;
        chk_cyc("sw_post", 3'd0, MRD);

        // complete sw, done in MEM
        tick();
        mem_ready = 1'b1; #1;
        chk_cyc("sw2_F", 3'd0, PCW | IRW | MRD);
        tick(); tick(); tick();
        mem_ready = 1'b0; #1;
        chk_cyc("sw2_Mwait", 3'd3, MWR);
        tick();
        mem_ready = 1'b1; #1;
        chk_cyc("sw2_Mdone", 3'd3, MWR | DONE);
        tick();
        chk("sw2_cnt", 32'(instr_count), 32'd1);
        chk("sw2_next", 32'(state), 32'd0);

        // mem_ready on the limit cycle wins over the timeout
        reset = 1'b1; #1; tick();
        reset = 1'b0; mem_ready = 1'b0; opcode = 6'b000000; function_code = 6'b100000;
        exp_cnt = 3'd0;
        for (int i = 0; i < 14; i++) begin
            #1;
            chk_cyc("lim_Fwait", 3'd0, MRD);
            tick();
        end
        mem_ready = 1'b1; #1;
        chk_cyc("lim_F", 3'd0, PCW | IRW | MRD);
        tick(); #1;
        chk_cyc("lim_D", 3'd1, 10'h000);
        tick(); #1;
        chk_cyc("lim_E", 3'd2, 10'h000);
        tick(); #1;
        chk_cyc("lim_W", 3'd4, RGW | RDST | DONE);
        tick();
        chk("lim_cnt", 32'(instr_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
